// File: rtl/bcd_multi_counter.sv
// rtl/bcd_multi_counter.sv - multi-digit radix-N up/down counter with wrap, saturate and one-shot limits
// Ripple digit arithmetic, inc edge detection, cascade carry/borrow, parallel load and clamp.
module bcd_multi_counter #(
  parameter int DIGITS = 4,
  parameter int RADIX  = 10,
  parameter int DW     = (RADIX > 2) ? $clog2(RADIX) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inc,
  input  logic                 cin,
  input  logic                 dir,
  input  logic [1:0]           mode,
  input  logic [DIGITS*DW-1:0] limit,
  input  logic                 load,
  input  logic [DIGITS*DW-1:0] load_val,
  input  logic                 clear,
  output logic [DIGITS*DW-1:0] cnt_out,
  output logic                 carry_out,
  output logic                 borrow_out,
  output logic                 at_zero,
  output logic                 at_limit,
  output logic                 done
);

  localparam logic [DW-1:0] MAXD = DW'(RADIX - 1);

  logic [DIGITS*DW-1:0] r_cnt;
  logic                 r_inc_q;
  logic                 r_arm;
  logic                 r_carry;
  logic                 r_borrow;
  logic                 r_done;

  logic [DIGITS*DW-1:0] w_lim;
  logic [DIGITS*DW-1:0] w_ld;
  logic [DIGITS*DW-1:0] w_up;
  logic [DIGITS*DW-1:0] w_dn;
  logic                 w_up_c;
  logic                 w_dn_b;
  logic                 w_gt;
  logic                 w_step;
  logic                 w_wrap;
  logic                 w_os;
  logic                 w_ge_lim;

  always_comb begin
    logic c_up;
    logic c_dn;
    logic decided;
    w_lim   = '0;
    w_ld    = '0;
    w_up    = '0;
    w_dn    = '0;
    w_gt    = 1'b0;
    c_up    = 1'b1;
    c_dn    = 1'b1;
    decided = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      w_lim[i*DW +: DW] = (limit[i*DW +: DW] > MAXD) ? MAXD : limit[i*DW +: DW];
      w_ld[i*DW +: DW]  = (load_val[i*DW +: DW] > MAXD) ? MAXD : load_val[i*DW +: DW];
      w_up[i*DW +: DW]  = r_cnt[i*DW +: DW];
      w_dn[i*DW +: DW]  = r_cnt[i*DW +: DW];
      if (c_up) begin
        if (r_cnt[i*DW +: DW] == MAXD) begin
          w_up[i*DW +: DW] = '0;
        end else begin
          w_up[i*DW +: DW] = r_cnt[i*DW +: DW] + DW'(1);
          c_up = 1'b0;
        end
      end
      if (c_dn) begin
        if (r_cnt[i*DW +: DW] == '0) begin
          w_dn[i*DW +: DW] = MAXD;
        end else begin
          w_dn[i*DW +: DW] = r_cnt[i*DW +: DW] - DW'(1);
          c_dn = 1'b0;
        end
      end
    end
    // Most significant digit decides the magnitude compare.
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (!decided) begin
        if (r_cnt[i*DW +: DW] > w_lim[i*DW +: DW]) begin
          w_gt    = 1'b1;
          decided = 1'b1;
        end else if (r_cnt[i*DW +: DW] < w_lim[i*DW +: DW]) begin
          decided = 1'b1;
        end
      end
    end
    w_up_c = c_up;
    w_dn_b = c_dn;
  end

  // r_arm blocks a step until inc has been seen low after reset.
  assign w_step   = (inc & ~r_inc_q & r_arm) | cin;
  assign w_wrap   = (mode == 2'b00);
  assign w_os     = (mode == 2'b10);
  assign at_zero  = (r_cnt == '0);
  assign at_limit = (r_cnt == w_lim);
  assign w_ge_lim = w_gt | at_limit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_inc_q  <= 1'b0;
      r_arm    <= 1'b0;
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_inc_q  <= inc;
      r_arm    <= r_arm | ~inc;
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
      if (clear) begin
        r_cnt  <= '0;
        r_done <= 1'b0;
      end else if (load) begin
        r_cnt  <= w_ld;
        r_done <= 1'b0;
      end else if (w_step && !(w_os && r_done)) begin
        if (w_wrap) begin
          if (!dir) begin
            r_cnt   <= w_up;
            r_carry <= w_up_c;
          end else begin
            r_cnt    <= w_dn;
            r_borrow <= w_dn_b;
          end
        end else if (!dir) begin
          if (w_ge_lim) begin
            r_cnt <= w_lim;
            if (w_os) r_done <= 1'b1;
          end else begin
            r_cnt <= w_up;
            if (w_os && (w_up == w_lim)) r_done <= 1'b1;
          end
        end else begin
          if (at_zero) begin
            if (w_os) r_done <= 1'b1;
          end else begin
            r_cnt <= w_dn;
            if (w_os && (w_dn == '0)) r_done <= 1'b1;
          end
        end
      end else if (!w_wrap && w_gt) begin
        r_cnt <= w_lim;
      end
    end
  end

  assign cnt_out    = r_cnt;
  assign carry_out  = r_carry;
  assign borrow_out = r_borrow;
  assign done       = r_done;

endmodule

// File: tb/tb_bcd_multi_counter.sv
// tb/tb_bcd_multi_counter.sv - bench for bcd_multi_counter (4 decimal digits)
// Directed scenarios plus randomized stimulus against an integer-valued reference model.
module tb_bcd_multi_counter;

  localparam int N = 10000;

  logic        clk = 1'b0;
  logic        reset, inc, cin, dir, load, clear;
  logic [1:0]  mode;
  logic [15:0] limit, load_val;
  logic [15:0] cnt_out;
  logic        carry_out, borrow_out, at_zero, at_limit, done;

  int n_cmp = 0;
  int n_err = 0;

  int m_cnt;
  bit m_prev, m_done, m_carry, m_borrow;

  bcd_multi_counter #(.DIGITS(4), .RADIX(10), .DW(4)) dut (
    .clk(clk), .reset(reset), .inc(inc), .cin(cin), .dir(dir), .mode(mode),
    .limit(limit), .load(load), .load_val(load_val), .clear(clear),
    .cnt_out(cnt_out), .carry_out(carry_out), .borrow_out(borrow_out),
    .at_zero(at_zero), .at_limit(at_limit), .done(done)
  );

  always #5 clk = ~clk;

  function automatic int san(input logic [15:0] x);
    int v = 0;
    int w = 1;
    for (int i = 0; i < 4; i++) begin
      int d = int'((x >> (4 * i)) & 16'hF);
      if (d > 9) d = 9;
      v += d * w;
      w *= 10;
    end
    return v;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v /= 10;
    end
    return r;
  endfunction

  // After reset the level of inc counts as already high: a fresh rise is needed.
  task automatic model_reset();
    m_cnt = 0; m_prev = 1'b1; m_done = 1'b0; m_carry = 1'b0; m_borrow = 1'b0;
  endtask

  task automatic model_edge();
    int lim;
    bit step;
    lim      = san(limit);
    step     = (inc && !m_prev) || cin;
    m_prev   = inc;
    m_carry  = 1'b0;
    m_borrow = 1'b0;
    if (clear) begin
      m_cnt = 0; m_done = 1'b0;
    end else if (load) begin
      m_cnt = san(load_val); m_done = 1'b0;
    end else if (step && !(mode == 2'b10 && m_done)) begin
      if (mode == 2'b00) begin
        if (!dir) begin
          if (m_cnt == N - 1) begin m_cnt = 0; m_carry = 1'b1; end
          else m_cnt = m_cnt + 1;
        end else begin
          if (m_cnt == 0) begin m_cnt = N - 1; m_borrow = 1'b1; end
          else m_cnt = m_cnt - 1;
        end
      end else if (!dir) begin
        m_cnt = (m_cnt >= lim) ? lim : m_cnt + 1;
        if (mode == 2'b10 && m_cnt == lim) m_done = 1'b1;
      end else begin
        m_cnt = (m_cnt == 0) ? 0 : m_cnt - 1;
        if (mode == 2'b10 && m_cnt == 0) m_done = 1'b1;
      end
    end else if (mode != 2'b00 && m_cnt > lim) begin
      m_cnt = lim;
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    inc = 1'b1; cycle();
    inc = 1'b0; cycle();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    inc = 0; cin = 0; dir = 0; mode = 2'b00; limit = 16'h9999;
    load = 0; load_val = 16'h0000; clear = 0;
    apply_reset();
    n_cmp++;
    if ({cnt_out, carry_out, borrow_out, done, at_zero} !== {16'h0000, 4'b0001}) begin
      n_err++;
      $display("FAIL reset_state got cnt=%h c=%b b=%b d=%b z=%b want 0000 0 0 0 1",
               cnt_out, carry_out, borrow_out, done, at_zero);
    end
  endtask

  task automatic test_hold_inc();
    apply_reset();
    inc = 0; cycle();
    inc = 1;
    repeat (5) cycle();
    n_cmp++;
    if (cnt_out !== 16'h0001) begin
      n_err++; $display("FAIL hold_inc_single_step got %h want 0001", cnt_out);
    end
    inc = 0; cycle();
  endtask

  task automatic test_wrap();
    mode = 2'b00; dir = 0;
    load_val = 16'h9999; load = 1; cycle(); load = 0;
    inc = 1; cycle();
    n_cmp++;
    if ({cnt_out, carry_out} !== {16'h0000, 1'b1}) begin
      n_err++; $display("FAIL wrap_up got cnt=%h carry=%b want 0000 1", cnt_out, carry_out);
    end
    inc = 0; cycle();
    n_cmp++;
    if (carry_out !== 1'b0) begin
      n_err++; $display("FAIL carry_one_cycle got %b want 0", carry_out);
    end
    dir = 1; inc = 1; cycle();
    n_cmp++;
    if ({cnt_out, borrow_out, carry_out} !== {16'h9999, 2'b10}) begin
      n_err++; $display("FAIL wrap_down got cnt=%h borrow=%b carry=%b want 9999 1 0",
                        cnt_out, borrow_out, carry_out);
    end
    inc = 0; cycle();
    n_cmp++;
    if (borrow_out !== 1'b0) begin
      n_err++; $display("FAIL borrow_one_cycle got %b want 0", borrow_out);
    end
    dir = 0;
  endtask

  task automatic test_saturate();
    mode = 2'b01; limit = 16'h0012;
    clear = 1; cycle(); clear = 0;
    repeat (15) pulse();
    n_cmp++;
    if ({cnt_out, at_limit} !== {16'h0012, 1'b1}) begin
      n_err++; $display("FAIL saturate got cnt=%h at_limit=%b want 0012 1", cnt_out, at_limit);
    end
    limit = 16'h0005; cycle();
    n_cmp++;
    if ({cnt_out, carry_out} !== {16'h0005, 1'b0}) begin
      n_err++; $display("FAIL clamp got cnt=%h carry=%b want 0005 0", cnt_out, carry_out);
    end
  endtask

  task automatic test_oneshot();
    mode = 2'b10; limit = 16'h0003;
    clear = 1; cycle(); clear = 0;
    repeat (2) pulse();
    n_cmp++;
    if ({cnt_out, done} !== {16'h0002, 1'b0}) begin
      n_err++; $display("FAIL oneshot_before got cnt=%h done=%b want 0002 0", cnt_out, done);
    end
    pulse();
    n_cmp++;
    if ({cnt_out, done} !== {16'h0003, 1'b1}) begin
      n_err++; $display("FAIL oneshot_reach got cnt=%h done=%b want 0003 1", cnt_out, done);
    end
    repeat (2) pulse();
    n_cmp++;
    if ({cnt_out, done} !== {16'h0003, 1'b1}) begin
      n_err++; $display("FAIL oneshot_ignore got cnt=%h done=%b want 0003 1", cnt_out, done);
    end
    load_val = 16'h0001; load = 1; cycle(); load = 0;
    n_cmp++;
    if ({cnt_out, done} !== {16'h0001, 1'b0}) begin
      n_err++; $display("FAIL oneshot_load got cnt=%h done=%b want 0001 0", cnt_out, done);
    end
    pulse();
    n_cmp++;
    if (cnt_out !== 16'h0002) begin
      n_err++; $display("FAIL oneshot_resume got %h want 0002", cnt_out);
    end
  endtask

  task automatic test_cin_and_sanitise();
    mode = 2'b00; dir = 0;
    load_val = 16'h0019; load = 1; cycle(); load = 0;
    inc = 1; cin = 1; cycle();
    inc = 0; cin = 0;
    n_cmp++;
    if (cnt_out !== 16'h0020) begin
      n_err++; $display("FAIL inc_cin_single got %h want 0020", cnt_out);
    end
    load_val = 16'h00F7; load = 1; cycle(); load = 0;
    n_cmp++;
    if (cnt_out !== 16'h0097) begin
      n_err++; $display("FAIL load_sanitise got %h want 0097", cnt_out);
    end
    cin = 1; cycle(); cin = 0;
    n_cmp++;
    if (cnt_out !== 16'h0098) begin
      n_err++; $display("FAIL cin_step got %h want 0098", cnt_out);
    end
  endtask

  task automatic test_async_reset();
    mode = 2'b00; dir = 0;
    load_val = 16'h0042; load = 1; cycle(); load = 0;
    inc = 1; cycle();
    #2 reset = 1;
    #1;
    model_reset();
    n_cmp++;
    if ({cnt_out, at_zero, done} !== {16'h0000, 2'b10}) begin
      n_err++; $display("FAIL async_reset got cnt=%h z=%b d=%b want 0000 1 0", cnt_out, at_zero, done);
    end
    @(negedge clk);
    reset = 0;
    repeat (3) cycle();
    n_cmp++;
    if (cnt_out !== 16'h0000) begin
      n_err++; $display("FAIL no_step_after_reset got %h want 0000", cnt_out);
    end
    inc = 0; cycle();
    inc = 1; cycle();
    n_cmp++;
    if (cnt_out !== 16'h0001) begin
      n_err++; $display("FAIL fresh_edge_step got %h want 0001", cnt_out);
    end
    inc = 0; cycle();
  endtask

  task automatic test_random();
    logic [20:0] got, want;
    for (int k = 0; k < 600; k++) begin
      clear    = ($urandom % 25) == 0;
      load     = ($urandom % 12) == 0;
      load_val = 16'($urandom);
      inc      = $urandom % 2;
      cin      = ($urandom % 6) == 0;
      if ($urandom % 8 == 0) dir = $urandom % 2;
      if ($urandom % 20 == 0) mode = 2'($urandom);
      if ($urandom % 30 == 0) limit = 16'($urandom);
      cycle();
      got  = {cnt_out, carry_out, borrow_out, done, at_zero, at_limit};
      want = {to_bcd(m_cnt), m_carry, m_borrow, m_done, m_cnt == 0, m_cnt == san(limit)};
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL random[%0d] got cnt=%h c/b/d/z/l=%b want cnt=%h c/b/d/z/l=%b",
                 k, got[20:5], got[4:0], want[20:5], want[4:0]);
      end
    end
    clear = 0; load = 0; inc = 0; cin = 0;
  endtask

  initial begin
    test_reset();
    test_hold_inc();
    test_wrap();
    test_saturate();
    test_oneshot();
    test_cin_and_sanitise();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
